seg_scan_ctrl: RTL and testbench

Scan controller for the two-digit seven-segment display. It takes a 4-bit binary value (0–15) and splits it into tens and units digits. It time-multiplexes the two digits onto a single shared segment decoder, driving the two active-low anodes in alternation, with a programmable dead-time between digits to suppress ghosting. A new value is applied only at a frame boundary, so the display never shows tens from one value and units from another.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/dwell_cnt.sv | 29 ++
 rtl/seg_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and digit-split helpers for the two-digit seven-segment scan controller.
package seg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHOW_U,
    BLANK_U,
    SHOW_T,
    BLANK_T
  } scan_state_t;

  typedef logic [3:0] bcd_t;

  // Input is 0..15, so the tens digit is at most 1 and one compare replaces a divide.
  function automatic bcd_t tens_of(input logic [3:0] v);
    return (v >= 4'd10) ? 4'd1 : 4'd0;
  endfunction

  function automatic bcd_t units_of(input logic [3:0] v);
    return (v >= 4'd10) ? v - 4'd10 : v;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dwell_cnt.sv
// Loadable down-counter; tc is high while the count sits at zero.
module dwell_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Two-digit display scanner: alternates units/tens anodes with dead-time and
// swaps in a new value only at the frame boundary (entry to SHOW_U).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYC = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter bit          LZ_BLANK  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] value,
  output logic [3:0] digit,
  output logic       an0,
  output logic       an1,
  output logic       frame_start
);

  localparam int unsigned CW        = $clog2(max_u(DIGIT_CYC, BLANK_CYC) + 1);
  localparam logic [CW-1:0] DIG_LD  = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] BLK_LD  = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
  localparam bit            HAS_BLK = (BLANK_CYC != 0);

  scan_state_t   state, state_nxt;
  logic [3:0]    pend, shown, shown_nxt;
  logic          cnt_clr, cnt_load, enter_u, tc;
  logic [CW-1:0] cnt_val;

  // Counter holds (dwell - 1) on state entry, so tc marks the last cycle of the state.
  dwell_cnt #(.W(CW)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (tc)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_val   = DIG_LD;
    enter_u   = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      cnt_clr   = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = SHOW_U;
          cnt_load  = 1'b1;
          enter_u   = 1'b1;
        end
        SHOW_U: if (tc) begin
          cnt_load = 1'b1;
          if (HAS_BLK) begin
            state_nxt = BLANK_U;
            cnt_val   = BLK_LD;
          end else begin
            state_nxt = SHOW_T;
          end
        end
        BLANK_U: if (tc) begin
          state_nxt = SHOW_T;
          cnt_load  = 1'b1;
        end
        SHOW_T: if (tc) begin
          cnt_load = 1'b1;
          if (HAS_BLK) begin
            state_nxt = BLANK_T;
            cnt_val   = BLK_LD;
          end else begin
            state_nxt = SHOW_U;
            enter_u   = 1'b1;
          end
        end
        BLANK_T: if (tc) begin
          state_nxt = SHOW_U;
          cnt_load  = 1'b1;
          enter_u   = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A load on the boundary edge goes straight to the display, bypassing pend.
  assign shown_nxt = enter_u ? (load ? value : pend) : shown;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend        <= '0;
      shown       <= '0;
      digit       <= '0;
      an0         <= 1'b1;
      an1         <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state       <= state_nxt;
      shown       <= shown_nxt;
      frame_start <= enter_u;
      if (load) pend <= value;
      unique case (state_nxt)
        SHOW_U: begin
          an0   <= 1'b0;
          an1   <= 1'b1;
          digit <= units_of(shown_nxt);
        end
        SHOW_T: begin
          an0   <= 1'b1;
          an1   <= LZ_BLANK && (tens_of(shown_nxt) == 4'd0);
          digit <= tens_of(shown_nxt);
        end
        default: begin
          an0 <= 1'b1;
          an1 <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: a frame-phase reference model pushes expected outputs each
// rising edge; three differently parameterised DUTs are compared on falling edges.
module tb_seg_scan_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       load  = 1'b0;
  logic [3:0] value = 4'd0;

  logic [2:0] an0_w, an1_w, fs_w;
  logic [3:0] dig_w [3];

  int checks = 0;
  int errors = 0;

  // Instance parameters: a = (4,2,LZ1), b = (4,2,LZ0), c = (3,0,LZ1)
  int p_d  [3] = '{4, 4, 3};
  int p_b  [3] = '{2, 2, 0};
  bit p_lz [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGIT_CYC(4), .BLANK_CYC(2), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .digit(dig_w[0]), .an0(an0_w[0]), .an1(an1_w[0]), .frame_start(fs_w[0]));

  seg_scan_ctrl #(.DIGIT_CYC(4), .BLANK_CYC(2), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .digit(dig_w[1]), .an0(an0_w[1]), .an1(an1_w[1]), .frame_start(fs_w[1]));

  seg_scan_ctrl #(.DIGIT_CYC(3), .BLANK_CYC(0), .LZ_BLANK(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .digit(dig_w[2]), .an0(an0_w[2]), .an1(an1_w[2]), .frame_start(fs_w[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position inside a frame of 2*(D+B) cycles selects the slot.
  bit         m_act   [3];
  int         m_ph    [3];
  logic [3:0] m_pend  [3];
  logic [3:0] m_shown [3];
  logic [3:0] m_dig   [3];
  logic       m_an0   [3];
  logic       m_an1   [3];
  logic       m_fs    [3];
  logic [20:0] sbq [$];

  always @(posedge clk) begin
    logic [20:0] e;
    logic [3:0]  t, u;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_act[i] = 1'b0; m_ph[i] = 0; m_pend[i] = 4'd0; m_shown[i] = 4'd0;
        m_dig[i] = 4'd0; m_an0[i] = 1'b1; m_an1[i] = 1'b1; m_fs[i] = 1'b0;
      end else begin
        if (!en) begin
          m_act[i] = 1'b0;
          m_fs[i]  = 1'b0;
        end else if (!m_act[i] || m_ph[i] == 2 * (p_d[i] + p_b[i]) - 1) begin
          m_act[i]   = 1'b1;
          m_ph[i]    = 0;
          m_shown[i] = load ? value : m_pend[i];
          m_fs[i]    = 1'b1;
        end else begin
          m_ph[i]++;
          m_fs[i] = 1'b0;
        end
        if (load) m_pend[i] = value;
        m_an0[i] = 1'b1;
        m_an1[i] = 1'b1;
        if (m_act[i]) begin
          u = m_shown[i] % 4'd10;
          t = m_shown[i] / 4'd10;
          if (m_ph[i] < p_d[i]) begin
            m_an0[i] = 1'b0;
            m_dig[i] = u;
          end else if (m_ph[i] >= p_d[i] + p_b[i] && m_ph[i] < 2 * p_d[i] + p_b[i]) begin
            m_an1[i] = p_lz[i] && (t == 4'd0);
            m_dig[i] = t;
          end
        end
      end
      e[i*7 +: 7] = {m_an0[i], m_an1[i], m_dig[i], m_fs[i]};
    end
    sbq.push_back(e);
  end

  always @(negedge clk) begin
    logic [20:0] e;
    logic [6:0]  exp7, got7;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      for (int i = 0; i < 3; i++) begin
        exp7 = rst_n ? e[i*7 +: 7] : 7'b11_0000_0;
        got7 = {an0_w[i], an1_w[i], dig_w[i], fs_w[i]};
        check($sformatf("scan%0d{an0,an1,digit,fs}", i), 32'(got7), 32'(exp7));
        check($sformatf("anodes_not_both_low%0d", i), 32'(an0_w[i] | an1_w[i]), 32'd1);
      end
    end
  end

  task automatic pulse_load(input logic [3:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_ph(input int target);
    bit found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      if (m_act[0] && m_ph[0] == target) found = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("wait_phase_%0d", target), 32'(found), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic scan of 13
    pulse_load(4'd13);
    en = 1'b1;
    repeat (30) @(negedge clk);

    // Leading-zero slot with value 7
    pulse_load(4'd7);
    repeat (26) @(negedge clk);

    // Tear-free update: 15 on screen, 9 loaded during the tens slot
    pulse_load(4'd15);
    repeat (26) @(negedge clk);
    wait_ph(6);
    pulse_load(4'd9);
    repeat (26) @(negedge clk);

    // Same-cycle bypass on the frame boundary edge
    wait_ph(11);
    value = 4'd12;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("bypass_digit", 32'(dig_w[0]), 32'd2);
    check("bypass_frame_start", 32'(fs_w[0]), 32'd1);
    repeat (6) @(negedge clk);

    // Enable toggle mid-SHOW_U, load while dark
    wait_ph(1);
    en = 1'b0;
    @(negedge clk);
    check("en_off_anodes", 32'({an0_w[0], an1_w[0]}), 32'd3);
    pulse_load(4'd4);
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("en_on_frame_start", 32'(fs_w[0]), 32'd1);
    check("en_on_digit", 32'(dig_w[0]), 32'd4);
    repeat (14) @(negedge clk);

    // Asynchronous reset while the tens digit of 13 is lit
    pulse_load(4'd13);
    begin
      bit found = 1'b0;
      for (int n = 0; n < 40 && !found; n++) begin
        if (an1_w[0] == 1'b0) found = 1'b1;
        else @(negedge clk);
      end
      check("wait_show_t", 32'(found), 32'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("async_rst_anodes%0d", i), 32'({an0_w[i], an1_w[i]}), 32'd3);
      check($sformatf("async_rst_digit%0d", i), 32'(dig_w[i]), 32'd0);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
